lab6_sequencer: RTL and testbench

Control sequencer sitting directly upstream of the Lab6 datapath (register file, bus multiplexer, ALU). It accepts one 9-bit register-level instruction per valid/ready handshake. It expands each instruction into a fixed micro-op sequence that drives reg_add, RNW, BS, WrA, WrB and ALUop cycle by cycle, allowing for the datapath's registered read, mux and ALU stages. It signals completion with a one-cycle done pulse.

---
 rtl/lab6_sequencer_if.sv | 28 ++
 rtl/lab6_sequencer.sv | 132 +++++++++++++
 tb/tb_lab6_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lab6_sequencer_if.sv
// Handshake and micro-op bus between an instruction issuer (master) and lab6_sequencer (slave).
interface lab6_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int SEL_W  = 3,
  parameter int OP_W   = 3
);
  logic [OP_W+2*ADDR_W-1:0] instr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [ADDR_W-1:0]        reg_add;
  logic                     RNW;
  logic [SEL_W-1:0]         BS;
  logic                     WrA;
  logic                     WrB;
  logic [OP_W-1:0]          ALUop;
  logic                     busy;
  logic                     done;

  modport master (
    output instr, instr_valid,
    input  instr_ready, reg_add, RNW, BS, WrA, WrB, ALUop, busy, done
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, reg_add, RNW, BS, WrA, WrB, ALUop, busy, done
  );
endinterface

// File: rtl/lab6_sequencer.sv
// Expands one register-level instruction into the Lab6 datapath micro-op sequence.
// Optional SEQ_INSTR_COUNT_EN adds a 16-bit completed-instruction counter output.
module lab6_sequencer #(
  parameter int ADDR_W = 3,
  parameter int SEL_W  = 3,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  lab6_sequencer_if.slave   bus
`ifdef SEQ_INSTR_COUNT_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  localparam logic [3:0] S_IDLE = 4'd0,  S_RDA = 4'd1,  S_MXA = 4'd2,  S_LDA  = 4'd3,
                         S_RDB  = 4'd4,  S_MXB = 4'd5,  S_LDB = 4'd6,  S_EXE  = 4'd7,
                         S_MXR  = 4'd8,  S_WR  = 4'd9,  S_MXC = 4'd10, S_WRC  = 4'd11,
                         S_DONE = 4'd12;

  localparam logic [OP_W-1:0]  OP_NOP = OP_W'(0), OP_LDI = OP_W'(1),
                               OP_INC = OP_W'(4), OP_DEC = OP_W'(5);
  localparam logic [SEL_W-1:0] BS_REG = SEL_W'(4), BS_ALU = SEL_W'(5);

  logic [3:0]        state, state_nx;
  logic [OP_W-1:0]   op_q, fn;
  logic [ADDR_W-1:0] ra_q, rb_q;
  logic              accept;

  logic [ADDR_W-1:0] reg_add;
  logic              RNW, WrA, WrB;
  logic [SEL_W-1:0]  BS;
  logic [OP_W-1:0]   ALUop;

  assign accept = bus.instr_valid && (state == S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= bus.instr[2*ADDR_W +: OP_W];
        ra_q <= bus.instr[ADDR_W +: ADDR_W];
        rb_q <= bus.instr[0 +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
        case (bus.instr[2*ADDR_W +: OP_W])
          OP_NOP:  state_nx = S_DONE;
          OP_LDI:  state_nx = S_MXC;
          default: state_nx = S_RDA;
        endcase
      end
      S_RDA:  state_nx = S_MXA;
      S_MXA:  state_nx = S_LDA;
      // unary ops only need buffer A, so skip the B fetch
      S_LDA:  state_nx = (op_q == OP_INC || op_q == OP_DEC) ? S_EXE : S_RDB;
      S_RDB:  state_nx = S_MXB;
      S_MXB:  state_nx = S_LDB;
      S_LDB:  state_nx = S_EXE;
      S_EXE:  state_nx = S_MXR;
      S_MXR:  state_nx = S_WR;
      S_WR:   state_nx = S_DONE;
      S_MXC:  state_nx = S_WRC;
      S_WRC:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_W'(2): fn = OP_W'(1);
      OP_W'(3): fn = OP_W'(2);
      OP_W'(4): fn = OP_W'(3);
      OP_W'(5): fn = OP_W'(4);
      OP_W'(6): fn = OP_W'(5);
      OP_W'(7): fn = OP_W'(6);
      default:  fn = '0;
    endcase
  end

  // ALUop and BS stay up through the write so the ALU result and DataIn stay valid
  always_comb begin
    reg_add = '0;
    RNW     = 1'b1;
    BS      = '0;
    WrA     = 1'b0;
    WrB     = 1'b0;
    ALUop   = '0;
    case (state)
      S_RDA:        reg_add = ra_q;
      S_MXA, S_MXB: BS = BS_REG;
      S_LDA:        begin BS = BS_REG; WrA = 1'b1; end
      S_RDB:        reg_add = rb_q;
      S_LDB:        begin BS = BS_REG; WrB = 1'b1; end
      S_EXE:        ALUop = fn;
      S_MXR:        begin ALUop = fn; BS = BS_ALU; end
      S_WR:         begin ALUop = fn; BS = BS_ALU; reg_add = ra_q; RNW = 1'b0; end
      S_MXC:        BS = SEL_W'(rb_q[1:0]);
      S_WRC:        begin BS = SEL_W'(rb_q[1:0]); reg_add = ra_q; RNW = 1'b0; end
      default: ;
    endcase
  end

  assign bus.reg_add     = reg_add;
  assign bus.RNW         = RNW;
  assign bus.BS          = BS;
  assign bus.WrA         = WrA;
  assign bus.WrB         = WrB;
  assign bus.ALUop       = ALUop;
  assign bus.instr_ready = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);

`ifdef SEQ_INSTR_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              instr_count <= '0;
    else if (state == S_DONE)  instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lab6_sequencer.sv
// Directed bench for lab6_sequencer driving a small behavioural model of the Lab6 datapath.
module tb_lab6_sequencer;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  lab6_sequencer_if #(.ADDR_W(3), .SEL_W(3), .OP_W(3)) bus ();
`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  lab6_sequencer #(.ADDR_W(3), .SEL_W(3), .OP_W(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef SEQ_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  // Datapath model: registered read, registered mux, buffers A/B, registered ALU
  logic [7:0] rf [8];
  logic [7:0] rd_q = 8'd0, bus_q = 8'd0, a_q = 8'd0, b_q = 8'd0, alu_q = 8'd0;
  logic [7:0] mux_v, prod;
  int wr_cnt = 0, done_cnt = 0;

  always_comb begin
    prod = 8'(a_q * b_q);
    case (bus.BS)
      3'd0: mux_v = 8'd0;
      3'd1: mux_v = 8'd1;
      3'd2: mux_v = 8'd2;
      3'd3: mux_v = 8'd4;
      3'd4: mux_v = rd_q;
      3'd5: mux_v = alu_q;
      default: mux_v = 8'd0;
    endcase
  end

  always @(posedge clock) begin
    if (bus.RNW) rd_q <= rf[bus.reg_add];
    else begin
      rf[bus.reg_add] <= bus_q;
      wr_cnt = wr_cnt + 1;
    end
    if (bus.done) done_cnt = done_cnt + 1;
    bus_q <= mux_v;
    if (bus.ALUop == 3'd0) begin
      if (bus.WrA) a_q <= bus_q;
      if (bus.WrB) b_q <= bus_q;
    end
    case (bus.ALUop)
      3'd1: alu_q <= a_q + b_q;
      3'd2: alu_q <= a_q - b_q;
      3'd3: alu_q <= a_q + 8'd1;
      3'd4: alu_q <= a_q - 8'd1;
      3'd5: alu_q <= a_q & b_q;
      3'd6: alu_q <= prod;
      default: alu_q <= 8'd0;
    endcase
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // {reg_add, RNW, BS, WrA, WrB, ALUop, busy, done, instr_ready}
  function automatic int mk(int ra, int rnw, int bs, int wa, int wb, int op, int bsy, int dn, int rdy);
    return (ra << 12) | (rnw << 11) | (bs << 8) | (wa << 7) | (wb << 6) | (op << 3) | (bsy << 2) | (dn << 1) | rdy;
  endfunction

  function automatic int obs();
    return mk(int'(bus.reg_add), int'(bus.RNW), int'(bus.BS), int'(bus.WrA), int'(bus.WrB),
              int'(bus.ALUop), int'(bus.busy), int'(bus.done), int'(bus.instr_ready));
  endfunction

  task automatic run_instr(input logic [8:0] ins, output int lat, output int wr);
    int wr0;
    @(negedge clock);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    wr0 = wr_cnt;
    @(negedge clock);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    wr = wr_cnt - wr0;
  endtask

  typedef struct {
    logic [8:0] ins;
    int         rg;
    int         val;
    int         lat;
    int         wr;
  } vec_t;

  vec_t vt[11];
  int   tr[14];

  initial begin
    int lat, wr, wr0, dn0;
    for (int i = 0; i < 8; i++) rf[i] = 8'd0;
    vt[0]  = '{9'b001_001_010, 1, 2,    3,  1};  // LDI R1,#2
    vt[1]  = '{9'b001_001_011, 1, 4,    3,  1};  // LDI R1,#4
    vt[2]  = '{9'b001_010_001, 2, 1,    3,  1};  // LDI R2,#1
    vt[3]  = '{9'b010_001_010, 1, 5,    10, 1};  // ADD R1,R2
    vt[4]  = '{9'b001_011_011, 3, 4,    3,  1};  // LDI R3,#4
    vt[5]  = '{9'b111_011_011, 3, 16,   10, 1};  // MUL R3,R3
    vt[6]  = '{9'b011_011_011, 3, 0,    10, 1};  // SUB R3,R3
    vt[7]  = '{9'b101_011_000, 3, 255,  7,  1};  // DEC R3 wraps
    vt[8]  = '{9'b100_011_000, 3, 0,    7,  1};  // INC R3 wraps
    vt[9]  = '{9'b110_001_010, 1, 1,    10, 1};  // AND R1,R2
    vt[10] = '{9'b000_000_000, 1, 1,    1,  0};  // NOP

    // ADD R1,R2 then LDI R5,#4 with instr_valid held high throughout
    tr[0]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0);
    tr[1]  = mk(0, 1, 4, 0, 0, 0, 1, 0, 0);
    tr[2]  = mk(0, 1, 4, 1, 0, 0, 1, 0, 0);
    tr[3]  = mk(2, 1, 0, 0, 0, 0, 1, 0, 0);
    tr[4]  = mk(0, 1, 4, 0, 0, 0, 1, 0, 0);
    tr[5]  = mk(0, 1, 4, 0, 1, 0, 1, 0, 0);
    tr[6]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0);
    tr[7]  = mk(0, 1, 5, 0, 0, 1, 1, 0, 0);
    tr[8]  = mk(1, 0, 5, 0, 0, 1, 1, 0, 0);
    tr[9]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 0);
    tr[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1);
    tr[11] = mk(0, 1, 3, 0, 0, 0, 1, 0, 0);
    tr[12] = mk(5, 0, 3, 0, 0, 0, 1, 0, 0);
    tr[13] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0);

    bus.instr = 9'd0;
    bus.instr_valid = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_outputs", obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_instr(vt[i].ins, lat, wr);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_writes", i), wr, vt[i].wr);
      chk($sformatf("v%0d_R%0d", i, vt[i].rg), int'(rf[vt[i].rg]), vt[i].val);
    end

    // held valid: second instruction latched only after the ADD completes
    @(negedge clock);
    wr0 = wr_cnt;
    bus.instr = 9'b010_001_010;
    bus.instr_valid = 1'b1;
    @(negedge clock);
    bus.instr = 9'b001_101_011;
    for (int c = 0; c < 14; c++) begin
      chk($sformatf("trace_c%0d", c + 1), obs(), tr[c]);
      @(negedge clock);
      if (c == 11) bus.instr_valid = 1'b0;
    end
    chk("held_writes", wr_cnt - wr0, 2);
    chk("held_R1", int'(rf[1]), 2);
    chk("held_R5", int'(rf[5]), 4);

    // reset during EXE of ADD R1,R2
    wr0 = wr_cnt;
    dn0 = done_cnt;
    bus.instr = 9'b010_001_010;
    bus.instr_valid = 1'b1;
    @(negedge clock);
    bus.instr_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("pre_abort_state", obs(), mk(0, 1, 0, 0, 0, 1, 1, 0, 0));
    #1 reset_n = 1'b0;
    #1 chk("abort_async", obs(), mk(0, 1, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("abort_writes", wr_cnt - wr0, 0);
    chk("abort_done", done_cnt - dn0, 0);
    chk("abort_R1", int'(rf[1]), 2);
    run_instr(9'b000_000_000, lat, wr);
    chk("nop_after_abort_lat", lat, 1);

    run_instr(9'b001_110_001, lat, wr);  // LDI R6,#1
    run_instr(9'b100_110_000, lat, wr);  // INC R6
    run_instr(9'b010_110_110, lat, wr);  // ADD R6,R6
    run_instr(9'b011_110_010, lat, wr);  // SUB R6,R2
    chk("mixed_R6", int'(rf[6]), 3);
    chk("mixed_last_lat", lat, 10);
`ifdef SEQ_INSTR_COUNT_EN
    chk("count_five", int'(instr_count), 5);
    @(negedge clock);
    force dut.instr_count = 16'hFFFF;
    #1 release dut.instr_count;
    run_instr(9'b000_000_000, lat, wr);
    @(negedge clock);
    chk("count_wrap", int'(instr_count), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
